// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: consumer side of timing_memory. Fetches one delay per
// light phase, counts it down, walks 5 phases per road and rotates round-robin
// over all roads, driving registered per-road lamp outputs.
// Optional build macro SEQ_FAULT_DETECT_EN: a zero or all-ones delay read in LOAD
// is treated as a memory fault and locks the sequencer into a flashing-yellow
// FLASH state until reset; the fault output is sticky.
module traffic_phase_sequencer #(
    parameter int states    = 6,
    parameter int roads     = 4,
    parameter int lights    = 5,
    parameter int count_max = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    input  logic [$clog2(count_max)-1:0] timing_data,
    output logic [$clog2(roads)-1:0]     road_address,
    output logic [$clog2(states)-1:0]    light_address,
    output logic                         timing_enable,
    output logic [roads-1:0]             green,
    output logic [roads-1:0]             yellow,
    output logic [roads-1:0]             red,
    output logic                         phase_done,
    output logic                         fault
);

    localparam int CW = $clog2(count_max);
    localparam int RW = $clog2(roads);
    localparam int LW = $clog2(states);
    localparam logic [LW-1:0] LAST_LIGHT = LW'(lights - 1);
    localparam logic [RW-1:0] LAST_ROAD  = RW'(roads - 1);

`ifdef SEQ_FAULT_DETECT_EN
    typedef enum logic [1:0] {FETCH, LOAD, COUNT, FLASH} state_t;
    localparam logic [CW-1:0] FLASH_LAST = CW'(count_max - 1);
`else
    typedef enum logic [1:0] {FETCH, LOAD, COUNT} state_t;
`endif

    state_t          state_q, state_d;
    logic            started_q;   // low only in the cycle right after reset release
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   road_q, road_d;
    logic [LW-1:0]   light_q, light_d;
    logic            te_q;
    logic [roads-1:0] green_q, green_d;
    logic [roads-1:0] yellow_q, yellow_d;
    logic [roads-1:0] red_q, red_d;
`ifdef SEQ_FAULT_DETECT_EN
    logic            fault_q, fault_d;
    logic [CW-1:0]   flash_cnt_q, flash_cnt_d;
`endif

    // Next-state logic: phase FSM, countdown and round-robin address advance
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        road_d     = road_q;
        light_d    = light_q;
        phase_done = 1'b0;
`ifdef SEQ_FAULT_DETECT_EN
        fault_d    = fault_q;
`endif
        if (!started_q) begin
            // First edge after reset launches the FETCH of road 0, phase 0
            state_d = FETCH;
        end else begin
            case (state_q)
                FETCH: state_d = LOAD;
                LOAD: begin
`ifdef SEQ_FAULT_DETECT_EN
                    if (timing_data == '1 || timing_data == '0) begin
                        state_d = FLASH;
                        fault_d = 1'b1;
                        road_d  = '0;
                        light_d = '0;
                    end else begin
                        cnt_d   = timing_data;
                        state_d = COUNT;
                    end
`else
                    // A zero delay still gives the phase one count cycle
                    cnt_d   = (timing_data == '0) ? CW'(1) : timing_data;
                    state_d = COUNT;
`endif
                end
                COUNT: begin
                    if (run) begin
                        if (cnt_q == CW'(1)) begin
                            phase_done = 1'b1;
                            state_d    = FETCH;
                            if (light_q == LAST_LIGHT) begin
                                light_d = '0;
                                road_d  = (road_q == LAST_ROAD) ? '0 : road_q + 1'b1;
                            end else begin
                                light_d = light_q + 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
`ifdef SEQ_FAULT_DETECT_EN
                FLASH: state_d = FLASH;
`endif
                default: state_d = FETCH;
            endcase
        end
    end

    // Lamp decode from the next address so lamps change on the same edge as the phase
    always_comb begin
        red_d    = '1;
        green_d  = '0;
        yellow_d = '0;
`ifdef SEQ_FAULT_DETECT_EN
        flash_cnt_d = flash_cnt_q;
`endif
        case (light_d)
            LW'(0): yellow_d[road_d] = 1'b1;
            LW'(1): begin
                green_d[road_d] = 1'b1;
                red_d[road_d]   = 1'b0;
            end
            LW'(2): begin
                yellow_d[road_d] = 1'b1;
                red_d[road_d]    = 1'b0;
            end
            default: ;
        endcase
`ifdef SEQ_FAULT_DETECT_EN
        if (state_d == FLASH) begin
            red_d   = '0;
            green_d = '0;
            if (state_q != FLASH) begin
                yellow_d    = '1;
                flash_cnt_d = '0;
            end else if (flash_cnt_q == FLASH_LAST) begin
                yellow_d    = ~yellow_q;
                flash_cnt_d = '0;
            end else begin
                yellow_d    = yellow_q;
                flash_cnt_d = flash_cnt_q + 1'b1;
            end
        end
`endif
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            started_q <= 1'b0;
            cnt_q     <= '0;
            road_q    <= '0;
            light_q   <= '0;
            te_q      <= 1'b0;
            green_q   <= '0;
            yellow_q  <= '0;
            red_q     <= '1;
`ifdef SEQ_FAULT_DETECT_EN
            fault_q     <= 1'b0;
            flash_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            cnt_q     <= cnt_d;
            road_q    <= road_d;
            light_q   <= light_d;
            te_q      <= (state_d == FETCH);
            green_q   <= green_d;
            yellow_q  <= yellow_d;
            red_q     <= red_d;
`ifdef SEQ_FAULT_DETECT_EN
            fault_q     <= fault_d;
            flash_cnt_q <= flash_cnt_d;
`endif
        end
    end

    assign road_address  = road_q;
    assign light_address = light_q;
    assign timing_enable = te_q;
    assign green         = green_q;
    assign yellow        = yellow_q;
    assign red           = red_q;
`ifdef SEQ_FAULT_DETECT_EN
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer with a registered timing_memory model.
module tb_traffic_phase_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [3:0] timing_data;
    logic [1:0] road_address;
    logic [2:0] light_address;
    logic       timing_enable;
    logic [3:0] green, yellow, red;
    logic       phase_done;
    logic       fault;

    int checks = 0;
    int errors = 0;

    logic       ovr_en  = 1'b0;
    logic [3:0] ovr_val = 4'd0;
    logic [3:0] mem_q   = 4'd0;

    typedef struct {
        int road;
        int light;
        int dur;
        int start;
    } exp_t;
    exp_t sb[$];

    traffic_phase_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .timing_data(timing_data),
        .road_address(road_address), .light_address(light_address),
        .timing_enable(timing_enable), .green(green), .yellow(yellow), .red(red),
        .phase_done(phase_done), .fault(fault)
    );

    always #5 clk = ~clk;

    // Delay table: even roads sum to 19, odd roads to 11
    function automatic int t_of(int r, int l);
        case (l)
            0: return 2;
            1: return (r % 2 == 1) ? 5 : 13;
            2: return 2;
            default: return 1;
        endcase
    endfunction

    // timing_memory: registers the delay at the end of the FETCH cycle
    always @(posedge clk)
        if (timing_enable)
            mem_q <= ovr_en ? ovr_val : 4'(t_of(int'(road_address), int'(light_address)));
    assign timing_data = mem_q;

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (road_address !== 2'd0 || light_address !== 3'd0) begin errors++; $display("FAIL reset_addr got road=%0d light=%0d want 0/0", road_address, light_address); end
        checks++; if (timing_enable !== 1'b0 || phase_done !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL reset_ctl got te=%b pd=%b fault=%b want 0/0/0", timing_enable, phase_done, fault); end
        checks++; if (red !== 4'hF || green !== 4'h0 || yellow !== 4'h0) begin errors++; $display("FAIL reset_lamps got r=%h g=%h y=%h want F/0/0", red, green, yellow); end
        reset = 1'b0;
        #1;
        checks++; if (timing_enable !== 1'b0 || red !== 4'hF) begin errors++; $display("FAIL reset_release got te=%b r=%h want 0/F", timing_enable, red); end
    endtask

    task automatic test_first_phase();
        do_reset();
        @(negedge clk); // cycle 1
        checks++; if (timing_enable !== 1'b1 || road_address !== 2'd0 || light_address !== 3'd0) begin errors++; $display("FAIL c1_fetch got te=%b road=%0d light=%0d want 1/0/0", timing_enable, road_address, light_address); end
        checks++; if (red !== 4'hF || yellow !== 4'h1 || green !== 4'h0) begin errors++; $display("FAIL c1_lamps got r=%h y=%h g=%h want F/1/0", red, yellow, green); end
        @(negedge clk); // cycle 2
        checks++; if (timing_enable !== 1'b0 || phase_done !== 1'b0) begin errors++; $display("FAIL c2 got te=%b pd=%b want 0/0", timing_enable, phase_done); end
        @(negedge clk); // cycle 3
        checks++; if (phase_done !== 1'b0) begin errors++; $display("FAIL c3_pd got %b want 0", phase_done); end
        @(negedge clk); // cycle 4
        checks++; if (phase_done !== 1'b1 || light_address !== 3'd0) begin errors++; $display("FAIL c4 got pd=%b light=%0d want 1/0", phase_done, light_address); end
        @(negedge clk); // cycle 5
        checks++; if (light_address !== 3'd1 || timing_enable !== 1'b1 || phase_done !== 1'b0) begin errors++; $display("FAIL c5 got light=%0d te=%b pd=%b want 1/1/0", light_address, timing_enable, phase_done); end
        checks++; if (green !== 4'h1 || red !== 4'hE || yellow !== 4'h0) begin errors++; $display("FAIL c5_lamps got g=%h r=%h y=%h want 1/E/0", green, red, yellow); end
    endtask

    task automatic test_rotation();
        int n = 0;
        int cr = 0, cl = 0;
        int g[4] = '{0, 0, 0, 0};
        logic [3:0] er, eg, ey;
        exp_t e;
        sb.delete();
        do_reset();
        for (int cyc = 1; cyc <= 101; cyc++) begin
            @(negedge clk);
            if (timing_enable === 1'b1) begin
                cr = (n / 5) % 4;
                cl = n % 5;
                checks++; if (road_address !== 2'(cr) || light_address !== 3'(cl)) begin errors++; $display("FAIL rot_addr n=%0d got road=%0d light=%0d want %0d/%0d", n, road_address, light_address, cr, cl); end
                e.road = cr; e.light = cl; e.dur = t_of(cr, cl) + 2; e.start = cyc;
                sb.push_back(e);
                n++;
            end
            er = 4'hF; eg = 4'h0; ey = 4'h0;
            case (cl)
                0: ey[cr] = 1'b1;
                1: begin eg[cr] = 1'b1; er[cr] = 1'b0; end
                2: begin ey[cr] = 1'b1; er[cr] = 1'b0; end
                default: ;
            endcase
            checks++; if (red !== er || green !== eg || yellow !== ey) begin errors++; $display("FAIL rot_lamps cyc=%0d got r=%h g=%h y=%h want %h/%h/%h", cyc, red, green, yellow, er, eg, ey); end
            for (int r = 0; r < 4; r++) g[r] += int'(green[r]);
            if (phase_done === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL rot_done cyc=%0d got phase_done with no phase pending want none", cyc);
                end else begin
                    e = sb.pop_front();
                    if (cyc - e.start + 1 != e.dur) begin errors++; $display("FAIL rot_dur road=%0d light=%0d got %0d want %0d", e.road, e.light, cyc - e.start + 1, e.dur); end
                end
            end
        end
        checks++; if (n != 21 || sb.size() != 1) begin errors++; $display("FAIL rot_count got fetches=%0d pending=%0d want 21/1", n, sb.size()); end
        checks++; if (g[0] != 15 || g[1] != 7 || g[2] != 15 || g[3] != 7) begin errors++; $display("FAIL rot_green got %0d %0d %0d %0d want 15 7 15 7", g[0], g[1], g[2], g[3]); end
    endtask

    task automatic test_run_freeze();
        int k = 0;
        int gc;
        do_reset();
        do begin
            @(negedge clk);
            k++;
        end while (!(timing_enable === 1'b1 && road_address === 2'd2 && light_address === 3'd1) && k < 200);
        checks++; if (k >= 200) begin errors++; $display("FAIL freeze_wait got timeout want road2 phase1 fetch"); return; end
        gc = int'(green[2]);
        for (int i = 1; i <= 30; i++) begin
            if (i == 5) run = 1'b0;
            if (i == 15) run = 1'b1;
            @(negedge clk);
            gc += int'(green[2]);
            if (i >= 6 && i <= 14) begin
                checks++; if (phase_done !== 1'b0 || light_address !== 3'd1 || green !== 4'h4 || red !== 4'hB) begin errors++; $display("FAIL freeze_hold i=%0d got pd=%b light=%0d g=%h r=%h want 0/1/4/B", i, phase_done, light_address, green, red); end
            end
            if (i == 24) begin
                checks++; if (phase_done !== 1'b1) begin errors++; $display("FAIL freeze_done got %b want 1", phase_done); end
            end
        end
        checks++; if (gc != 25) begin errors++; $display("FAIL freeze_green got %0d want 25", gc); end
    endtask

    task automatic test_reset_mid_phase();
        do_reset();
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (light_address !== 3'd0 || road_address !== 2'd0 || timing_enable !== 1'b0) begin errors++; $display("FAIL midreset_addr got light=%0d road=%0d te=%b want 0/0/0", light_address, road_address, timing_enable); end
        checks++; if (red !== 4'hF || green !== 4'h0 || yellow !== 4'h0 || phase_done !== 1'b0) begin errors++; $display("FAIL midreset_lamps got r=%h g=%h y=%h pd=%b want F/0/0/0", red, green, yellow, phase_done); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (timing_enable !== 1'b1 || light_address !== 3'd0 || yellow !== 4'h1) begin errors++; $display("FAIL midreset_restart got te=%b light=%0d y=%h want 1/0/1", timing_enable, light_address, yellow); end
    endtask

    task automatic test_all_ones();
        ovr_en  = 1'b1;
        ovr_val = 4'd15;
        do_reset();
`ifdef SEQ_FAULT_DETECT_EN
        for (int cyc = 1; cyc <= 35; cyc++) begin
            @(negedge clk);
            if (cyc < 3) begin
                checks++; if (fault !== 1'b0) begin errors++; $display("FAIL flash_pre cyc=%0d got fault=%b want 0", cyc, fault); end
            end else begin
                checks++; if (fault !== 1'b1 || red !== 4'h0 || green !== 4'h0 || timing_enable !== 1'b0 || yellow !== ((cyc <= 17 || cyc >= 33) ? 4'hF : 4'h0)) begin errors++; $display("FAIL flash cyc=%0d got fault=%b r=%h g=%h te=%b y=%h", cyc, fault, red, green, timing_enable, yellow); end
            end
        end
`else
        for (int cyc = 1; cyc <= 21; cyc++) begin
            @(negedge clk);
            if (cyc == 2) ovr_val = 4'd0;
            checks++; if (phase_done !== (cyc == 17 || cyc == 20) || fault !== 1'b0) begin errors++; $display("FAIL ones_pd cyc=%0d got pd=%b fault=%b want %b/0", cyc, phase_done, fault, (cyc == 17 || cyc == 20)); end
            if (cyc == 18) begin
                checks++; if (light_address !== 3'd1) begin errors++; $display("FAIL ones_adv got light=%0d want 1", light_address); end
            end
            if (cyc == 21) begin
                checks++; if (light_address !== 3'd2) begin errors++; $display("FAIL zero_adv got light=%0d want 2", light_address); end
            end
        end
`endif
        ovr_en = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        run   = 1'b1;
        test_reset();
        test_first_phase();
        test_rotation();
        test_run_freeze();
        test_reset_mid_phase();
        test_all_ones();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
